frame_capture_ctrl: RTL

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

---
 rtl/cam_pkg.sv | 22 ++
 rtl/cam_edge_detect.sv | 25 ++
 rtl/frame_capture_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the camera capture controller.
//   cap_state_e         - controller state encoding (IDLE/ARM/CAPTURE/DONE)
//   BYTES_PER_LINE_DEF  - default camera bytes per valid line
//   WORDS_W             - width of the written-word counter
//   cnt_width()         - bits needed to hold 0..max_val
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    localparam int BYTES_PER_LINE_DEF = 1280;
    localparam int WORDS_W            = 18;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cam_edge_detect.sv
// cam_edge_detect: registers one camera sync signal and flags its edges.
//   pclk  - camera pixel clock
//   reset - synchronous, active-high; clears the history register
//   sig   - raw input (href or vsync)
//   rise  - high in the cycle sig is 1 and was 0 on the previous edge
//   fall  - high in the cycle sig is 0 and was 1 on the previous edge
module cam_edge_detect (
    input  logic pclk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge pclk) begin
        if (reset) sig_q <= 1'b0;
        else       sig_q <= sig;
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: windows a band of camera lines into the byte packer and
// gates packed words into the downstream FIFO.
//
// Ports
//   pclk, reset            - pixel clock; synchronous active-high reset
//   vsync, href            - camera frame sync / line valid
//   start, abort           - single-cycle capture request / cancel
//   row_first, row_num     - line window, latched when start is accepted
//   pkt_valid, fifo_full   - packer word strobe, downstream backpressure
//   cap_en                 - registered byte-window enable to the packer
//   fifo_wr                - combinational FIFO write strobe
//   busy, done             - armed/capturing; one-cycle completion pulse
//   overflow, frame_err,
//   timeout                - sticky status, cleared on accepted start
//   words_written          - saturating count of words written
//   state                  - current controller state (cap_state_e)
//
// Build option
//   CAPTURE_CTRL_WATCHDOG_EN - adds a stall watchdog: no vsync/href edge for
//   WDOG_CYCLES cycles while armed/capturing sets timeout and ends the frame.
//   Undefined: timeout is tied low and no counter exists.
module frame_capture_ctrl
    import cam_pkg::*;
#(
    parameter int BYTES_PER_LINE = BYTES_PER_LINE_DEF,
    parameter int ROW_W          = 9,
    parameter int WDOG_CYCLES    = 2**20
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               href,
    input  logic               start,
    input  logic               abort,
    input  logic [ROW_W-1:0]   row_first,
    input  logic [ROW_W-1:0]   row_num,
    input  logic               pkt_valid,
    input  logic               fifo_full,
    output logic               cap_en,
    output logic               fifo_wr,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic               frame_err,
    output logic               timeout,
    output logic [WORDS_W-1:0] words_written,
    output logic [1:0]         state
);

    // One spare bit so an over-long line never aliases to BYTES_PER_LINE.
    localparam int BC_W = cnt_width(BYTES_PER_LINE) + 1;

    if (WDOG_CYCLES < 2 || BYTES_PER_LINE < 1) begin : g_param_chk
        $error("frame_capture_ctrl: WDOG_CYCLES must be >= 2, BYTES_PER_LINE >= 1");
    end

    cap_state_e       st;
    logic [ROW_W-1:0] row_first_q;
    logic [ROW_W-1:0] row_num_q;
    logic [ROW_W-1:0] line_cnt;
    logic [ROW_W:0]   row_end;
    logic [ROW_W:0]   row_last;
    logic [ROW_W:0]   line_x;
    logic [BC_W-1:0]  byte_cnt;
    logic             href_rise, href_fall;
    logic             vs_rise, vs_fall;
    logic             in_win, last_line, start_acc, wd_hit;

    cam_edge_detect u_href_edge (
        .pclk  (pclk),
        .reset (reset),
        .sig   (href),
        .rise  (href_rise),
        .fall  (href_fall)
    );

    cam_edge_detect u_vsync_edge (
        .pclk  (pclk),
        .reset (reset),
        .sig   (vsync),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    // Window bound is one bit wider so row_first+row_num cannot wrap.
    assign row_end   = {1'b0, row_first_q} + {1'b0, row_num_q};
    assign row_last  = row_end - (ROW_W+1)'(1);
    assign line_x    = {1'b0, line_cnt};
    assign in_win    = (line_x >= {1'b0, row_first_q}) && (line_x < row_end);
    assign last_line = (line_x == row_last);
    assign start_acc = (st == ST_IDLE) && start && !abort;

    assign fifo_wr = pkt_valid && !fifo_full && (st == ST_CAPTURE) && !reset;
    assign state   = st;

    // Bytes in the current href-high run; holds its value through the fall
    // cycle, which is where the line length is judged.
    always_ff @(posedge pclk) begin
        if (reset)
            byte_cnt <= '0;
        else if (href_rise)
            byte_cnt <= BC_W'(1);
        else if (href && !(&byte_cnt))
            byte_cnt <= byte_cnt + BC_W'(1);
    end

`ifdef CAPTURE_CTRL_WATCHDOG_EN
    localparam int WD_W = cnt_width(WDOG_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_active;
    logic            timeout_q;

    assign wd_active = (st == ST_ARM) || (st == ST_CAPTURE);
    assign wd_hit    = wd_active && (wd_cnt == WD_W'(WDOG_CYCLES - 1));
    assign timeout   = timeout_q;

    always_ff @(posedge pclk) begin
        if (reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (!wd_active || href_rise || href_fall || vs_rise || vs_fall)
                wd_cnt <= '0;
            else if (!wd_hit)
                wd_cnt <= wd_cnt + WD_W'(1);

            if (start_acc)
                timeout_q <= 1'b0;
            else if (wd_hit && !abort)
                timeout_q <= 1'b1;
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (reset) begin
            st            <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            cap_en        <= 1'b0;
            overflow      <= 1'b0;
            frame_err     <= 1'b0;
            words_written <= '0;
            line_cnt      <= '0;
            row_first_q   <= '0;
            row_num_q     <= '0;
        end else begin
            done   <= 1'b0;
            cap_en <= 1'b0;

            if (fifo_wr && !(&words_written))
                words_written <= words_written + WORDS_W'(1);

            // A word dropped even in the abort cycle still counts as overflow.
            if (pkt_valid && fifo_full && (st == ST_CAPTURE))
                overflow <= 1'b1;

            case (st)
                ST_IDLE: begin
                    if (start_acc) begin
                        row_first_q   <= row_first;
                        row_num_q     <= row_num;
                        overflow      <= 1'b0;
                        frame_err     <= 1'b0;
                        words_written <= '0;
                        busy          <= 1'b1;
                        st            <= ST_ARM;
                    end
                end

                ST_ARM: begin
                    if (abort) begin
                        busy <= 1'b0;
                        st   <= ST_IDLE;
                    end else if (wd_hit) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        st   <= ST_DONE;
                    end else if (vs_fall) begin
                        line_cnt <= '0;
                        if (row_num_q == '0) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            st   <= ST_DONE;
                        end else begin
                            st <= ST_CAPTURE;
                        end
                    end
                end

                ST_CAPTURE: begin
                    if (abort) begin
                        busy <= 1'b0;
                        st   <= ST_IDLE;
                    end else begin
                        // Registered one cycle behind href to line up with
                        // the packer's data register.
                        cap_en <= href && in_win;

                        if (href_fall) begin
                            line_cnt <= line_cnt + ROW_W'(1);
                            if (in_win && byte_cnt != BC_W'(BYTES_PER_LINE))
                                frame_err <= 1'b1;
                        end

                        if (href_fall && last_line) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            st   <= ST_DONE;
                        end else if (vs_rise) begin
                            // Frame ended before the window was complete.
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            st        <= ST_DONE;
                        end else if (wd_hit) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            st   <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    st <= ST_IDLE;
                end

                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule
